// File: rtl/fpu_div_arbiter.sv
// Round-robin front end sharing one iterative mantissa divider among NREQ requesters.
// Optional watchdog abort of a stalled divide is compiled in with `define DIV_TIMEOUT_EN.
module fpu_div_arbiter #(
  parameter int N       = 24,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_num1,
  input  logic [NREQ*N-1:0] req_num2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N:0]        rsp_quotient,
  output logic [N:0]        rsp_remainder,
  output logic              rsp_normalize,
  output logic              rsp_dbz,
  output logic              rsp_timeout,
  output logic              div_start,
  output logic [N-1:0]      div_num1,
  output logic [N-1:0]      div_num2,
  input  logic              div_done,
  input  logic [N:0]        div_quotient,
  input  logic [N:0]        div_remainder,
  input  logic              div_normalize
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("fpu_div_arbiter: NREQ must be 2..8 and TIMEOUT positive");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state, state_d;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           grant_ok;
  logic [N-1:0]   sel_num1, sel_num2;
  logic           wd_expire;

  // Rotating priority search starting at ptr.
  always_comb begin : arb
    int idx;
    grant_ok = 1'b0;
    grant    = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_ok && req_valid[idx]) begin
        grant_ok = 1'b1;
        grant    = IDW'(idx);
      end
    end
  end

  assign sel_num1 = req_num1[grant*N +: N];
  assign sel_num2 = req_num2[grant*N +: N];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_ok) req_ready[grant] = 1'b1;
  end

  assign div_start = (state == LAUNCH);
  assign rsp_valid = (state == RESP);

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          timeout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                wd_cnt <= '0;
    else if (state == LAUNCH) wd_cnt <= '0;
    else if (state == WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  // Expires on the TIMEOUT-th WAIT cycle; a done in that same cycle still wins.
  assign wd_expire   = (wd_cnt == CW'(TIMEOUT - 1));
  assign rsp_timeout = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (grant_ok) state_d = (sel_num2 == '0) ? RESP : LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (div_done || wd_expire) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr           <= '0;
      rsp_id        <= '0;
      div_num1      <= '0;
      div_num2      <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_normalize <= 1'b0;
      rsp_dbz       <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && grant_ok) begin
        div_num1 <= sel_num1;
        div_num2 <= sel_num2;
        rsp_id   <= grant;
        // Zero divisor answers immediately without touching the core.
        if (sel_num2 == '0) begin
          rsp_quotient  <= '1;
          rsp_remainder <= '0;
          rsp_normalize <= 1'b0;
          rsp_dbz       <= 1'b1;
`ifdef DIV_TIMEOUT_EN
          timeout_q     <= 1'b0;
`endif
        end
      end
      if (state == WAIT) begin
        if (div_done) begin
          rsp_quotient  <= div_quotient;
          rsp_remainder <= div_remainder;
          rsp_normalize <= div_normalize;
          rsp_dbz       <= 1'b0;
`ifdef DIV_TIMEOUT_EN
          timeout_q     <= 1'b0;
        end else if (wd_expire) begin
          rsp_quotient  <= '0;
          rsp_remainder <= '0;
          rsp_normalize <= 1'b0;
          rsp_dbz       <= 1'b0;
          timeout_q     <= 1'b1;
`endif
        end
      end
      if (state == RESP && rsp_ready)
        ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    end
  end

endmodule
